mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit.sv | 147 ++++++++++++++
 tb/tb_mult_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Sequential signed multiplier using radix-2 Booth recoding: one step per cycle, WIDTH steps per product.
// Optional overflow flag is compiled in when MULT_UNIT_OVERFLOW_EN is defined.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  // Accumulator carries one guard bit so subtracting the most-negative multiplicand cannot wrap.
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;
  logic             qm1_step;
  logic             accept;
  logic             last_step;

  always_comb begin
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand_ext;
      2'b10:   sum = acc_q - mcand_ext;
      default: sum = acc_q;
    endcase
    acc_step = {sum[WIDTH], sum[WIDTH:1]};
    q_step   = {sum[0], q_q[WIDTH-1:1]};
    qm1_step = q_q[0];
  end

  // A new request is taken in IDLE and also in DONE, so back-to-back operations need no bubble.
  assign accept    = start && (state_q != RUN);
  assign last_step = (state_q == RUN) && (cnt_q == 6'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        q_d   = q_step;
        qm1_d = qm1_step;
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          state_d  = DONE;
          result_d = q_step;
        end
      end
      DONE: begin
        state_d = accept ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (accept) begin
      mcand_d = data_a;
      q_d     = data_b;
      acc_d   = '0;
      qm1_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

`ifdef MULT_UNIT_OVERFLOW_EN
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   prod_hi;

  // The product fits in WIDTH bits exactly when its top WIDTH+1 bits are all copies of the sign.
  assign prod_hi = {acc_step[WIDTH-1:0], q_step[WIDTH-1]};

  always_comb begin
    ovf_d = ovf_q;
    if (last_step) begin
      ovf_d = !((&prod_hi) || !(|prod_hi));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign result = result_q;
  assign ready  = (state_q == DONE);
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner products, random operands against an
// integer-multiply reference, start-while-busy, reset abort and back-to-back operation.
module tb_mult_unit;

`ifdef MULT_UNIT_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic [31:0] result;
  logic        ready;
  logic        busy;
  logic        overflow;

  int total = 0;
  int bad = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data_a(data_a),
    .data_b(data_b),
    .result(result),
    .ready(ready),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit signed multiply.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    o = OVF_EN && ((p > 64'sd2147483647) || (p < -64'sd2147483648));
  endfunction

  // Drive a request; returns at the falling edge just after the accepting edge (cycle 1).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    data_a = a;
    data_b = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
  endtask

  // Step falling edges until ready, counting cycles since acceptance and busy dropouts.
  task automatic wait_ready(input int n0, output int n, output int busy_bad);
    n = n0;
    busy_bad = 0;
    while (ready !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total += 4;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=%h", result, 32'h0); end
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_basic;
    int n, bb;
    // Release reset and request on the same cycle: the very first edge must accept.
    @(negedge clk);
    reset  = 1'b0;
    data_a = 32'd3;
    data_b = 32'd4;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
    wait_ready(1, n, bb);
    $display("op basic a=3 b=4 result=%h ovf=%b latency=%0d", result, overflow, n);
    total += 6;
    if (n !== 33) begin bad++; $display("FAIL basic_latency got=%0d want=33", n); end
    if (bb !== 0) begin bad++; $display("FAIL basic_busy low_cycles=%0d want=0", bb); end
    if (result !== 32'h0000000C) begin bad++; $display("FAIL basic_result got=%h want=0000000c", result); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", overflow); end
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_ready got=%b want=0", busy); end
    @(negedge clk);
    if (ready !== 1'b0) begin bad++; $display("FAIL basic_pulse ready=%b want=0", ready); end
  endtask

  logic [31:0] dir_a [6] = '{32'hFFFFFFF9, 32'h80000000, 32'h7FFFFFFF, 32'h00010000, 32'h80000000, 32'h00000000};
  logic [31:0] dir_b [6] = '{32'h00000006, 32'hFFFFFFFF, 32'h00000002, 32'h00008000, 32'h80000000, 32'h12345678};
  logic [31:0] dir_r [6] = '{32'hFFFFFFD6, 32'h80000000, 32'hFFFFFFFE, 32'h80000000, 32'h00000000, 32'h00000000};
  logic        dir_o [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic test_directed;
    int n, bb;
    logic exp_o;
    for (int i = 0; i < 6; i++) begin
      start_op(dir_a[i], dir_b[i]);
      wait_ready(1, n, bb);
      exp_o = OVF_EN && dir_o[i];
      $display("op directed a=%h b=%h result=%h ovf=%b latency=%0d", dir_a[i], dir_b[i], result, overflow, n);
      total += 4;
      if (n !== 33 || bb !== 0) begin bad++; $display("FAIL dir_timing latency=%0d busy_low=%0d want 33/0", n, bb); end
      if (result !== dir_r[i]) begin bad++; $display("FAIL dir_result got=%h want=%h", result, dir_r[i]); end
      if (overflow !== exp_o) begin bad++; $display("FAIL dir_ovf got=%b want=%b", overflow, exp_o); end
      @(negedge clk);
      if (ready !== 1'b0) begin bad++; $display("FAIL dir_pulse ready=%b want=0", ready); end
    end
  endtask

  task automatic test_random;
    int n, bb;
    logic [31:0] a, b, exp_r;
    logic exp_o;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      if ($urandom_range(0, 2) == 0) a = $urandom_range(0, 200) - 100;
      model(a, b, exp_r, exp_o);
      start_op(a, b);
      wait_ready(1, n, bb);
      $display("op random a=%h b=%h result=%h ovf=%b", a, b, result, overflow);
      total += 3;
      if (n !== 33 || bb !== 0) begin bad++; $display("FAIL rnd_timing latency=%0d busy_low=%0d want 33/0", n, bb); end
      if (result !== exp_r) begin bad++; $display("FAIL rnd_result got=%h want=%h", result, exp_r); end
      if (overflow !== exp_o) begin bad++; $display("FAIL rnd_ovf got=%b want=%b", overflow, exp_o); end
      // Result and flag must be held through idle cycles.
      repeat ($urandom_range(1, 3)) @(negedge clk);
      total += 1;
      if (result !== exp_r) begin bad++; $display("FAIL rnd_hold got=%h want=%h", result, exp_r); end
    end
  endtask

  task automatic test_ignore_start;
    int n, bb, pulses;
    logic [31:0] held;
    held = result;
    start_op(32'd2, 32'd3);
    repeat (9) @(negedge clk);
    total += 1;
    if (result !== held) begin bad++; $display("FAIL ign_result_in_run got=%h want=%h", result, held); end
    data_a = 32'd5;
    data_b = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(11, n, bb);
    $display("op ignore_start a=2 b=3 result=%h latency=%0d", result, n);
    total += 3;
    if (n !== 33 || bb !== 0) begin bad++; $display("FAIL ign_timing latency=%0d busy_low=%0d want 33/0", n, bb); end
    if (result !== 32'd6) begin bad++; $display("FAIL ign_result got=%h want=%h", result, 32'd6); end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    if (pulses !== 0) begin bad++; $display("FAIL ign_extra_ready got=%0d want=0", pulses); end
  endtask

  task automatic test_reset_abort;
    int pulses;
    start_op($urandom, $urandom);
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    if (result !== 32'h0) begin bad++; $display("FAIL abort_result got=%h want=0", result); end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    $display("op reset_abort ready_pulses=%0d result=%h", pulses, result);
    if (pulses !== 0) begin bad++; $display("FAIL abort_ready got=%0d want=0", pulses); end
    if (result !== 32'h0) begin bad++; $display("FAIL abort_result_hold got=%h want=0", result); end
  endtask

  task automatic test_back_to_back;
    int n, bb;
    logic [31:0] exp_r;
    logic exp_o;
    model(32'd9, 32'hFFFFFFFD, exp_r, exp_o);
    start_op(32'd9, 32'hFFFFFFFD);
    // Hold start with the next operands through the run; only the ready cycle may take it.
    data_a = 32'd7;
    data_b = 32'd8;
    start  = 1'b1;
    wait_ready(1, n, bb);
    $display("op b2b_first a=9 b=-3 result=%h latency=%0d", result, n);
    total += 2;
    if (n !== 33 || bb !== 0) begin bad++; $display("FAIL b2b1_timing latency=%0d busy_low=%0d want 33/0", n, bb); end
    if (result !== exp_r) begin bad++; $display("FAIL b2b1_result got=%h want=%h", result, exp_r); end
    @(negedge clk);
    start  = 1'b0;
    data_a = $urandom;
    data_b = $urandom;
    wait_ready(1, n, bb);
    $display("op b2b_second a=7 b=8 result=%h latency=%0d", result, n);
    total += 2;
    if (n !== 33 || bb !== 0) begin bad++; $display("FAIL b2b2_timing latency=%0d busy_low=%0d want 33/0", n, bb); end
    if (result !== 32'd56) begin bad++; $display("FAIL b2b2_result got=%h want=%h", result, 32'd56); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
